iob_cache_port_arbiter: RTL and testbench

- Parametrised N-port IOb-native front-end arbiter placed between several requesters (PEs, DMA engines) and the single IOb slave port of an AXI-backed IOb cache.
- Arbitrates among requesters in round-robin or fixed-priority mode, and holds the grant stable while a request stalls.
- Tracks outstanding reads in a port-ID FIFO and steers each returning rvalid to the requester that issued the read.

---
 rtl/iob_cache_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_iob_cache_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// iob_cache_port_arbiter
//
// Front-end arbiter that lets N_PORTS IOb-native requesters share the single
// IOb slave port of a cache. Requests are granted in round-robin
// (ARB_MODE = 0) or fixed-priority (ARB_MODE = 1, port 0 highest) order. A
// stalled or FIFO-blocked request locks the grant until it is accepted.
// Accepted reads push their port index into a tag FIFO so that each returning
// m_rvalid_i is steered to the requester that issued the read.
//
// Ports:
//   clk_i, rst_i, cke_i   clock, synchronous active-high reset, clock enable
//   s_*                   packed per-requester IOb slave ports (port p at
//                         [p*W +: W]); s_rdata_o is m_rdata_i replicated
//   m_*                   IOb master port towards the cache
//   pending_o             number of reads accepted but not yet returned
//   err_o                 sticky: rvalid arrived with no outstanding read
// ---------------------------------------------------------------------------
module iob_cache_port_arbiter #(
    parameter int N_PORTS  = 4,
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int OUTST_W  = 2,
    parameter int ARB_MODE = 0,
    parameter int PORT_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cke_i,
    input  logic [N_PORTS-1:0]                 s_avalid_i,
    input  logic [N_PORTS*ADDR_W-1:0]          s_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]          s_wdata_i,
    input  logic [N_PORTS*(DATA_W/8)-1:0]      s_wstrb_i,
    output logic [N_PORTS-1:0]                 s_ready_o,
    output logic [N_PORTS-1:0]                 s_rvalid_o,
    output logic [N_PORTS*DATA_W-1:0]          s_rdata_o,
    output logic                               m_avalid_o,
    output logic [ADDR_W-1:0]                  m_addr_o,
    output logic [DATA_W-1:0]                  m_wdata_o,
    output logic [DATA_W/8-1:0]                m_wstrb_o,
    input  logic                               m_ready_i,
    input  logic                               m_rvalid_i,
    input  logic [DATA_W-1:0]                  m_rdata_i,
    output logic [OUTST_W:0]                   pending_o,
    output logic                               err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 2 ** OUTST_W;

    logic                lock_q, lock_d;
    logic [PORT_W-1:0]   lock_port_q, lock_port_d;
    logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OUTST_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OUTST_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OUTST_W:0]    count_q, count_d;
    logic                err_q, err_d;
    logic [PORT_W-1:0]   fifo_mem_q [DEPTH];
    logic [PORT_W-1:0]   fifo_mem_d [DEPTH];

    logic [PORT_W-1:0]   grant;
    logic                found;
    int                  idx;
    logic                gnt_avalid;
    logic                gnt_is_read;
    logic                fifo_full;
    logic                fifo_empty;
    logic                rd_block;
    logic                accept;
    logic                push;
    logic                pop;

    // Grant search. Round-robin starts at the pointer, fixed priority at 0;
    // a locked request overrides both so a stalled port keeps its grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_port_q;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                idx = ((ARB_MODE == 0) ? int'(rr_ptr_q) : 0) + i;
                if (idx >= N_PORTS) idx = idx - N_PORTS;
                if (!found && s_avalid_i[PORT_W'(idx)]) begin
                    grant = PORT_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign gnt_avalid  = s_avalid_i[grant];
    assign m_addr_o    = s_addr_i[int'(grant)*ADDR_W +: ADDR_W];
    assign m_wdata_o   = s_wdata_i[int'(grant)*DATA_W +: DATA_W];
    assign m_wstrb_o   = s_wstrb_i[int'(grant)*STRB_W +: STRB_W];
    assign gnt_is_read = (m_wstrb_o == '0);

    // Full check ignores a same-cycle pop: a blocked read waits one extra cycle.
    assign fifo_full  = (count_q == (OUTST_W+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign rd_block   = gnt_is_read & fifo_full;

    assign m_avalid_o = gnt_avalid & cke_i & ~rd_block;
    assign accept     = m_avalid_o & m_ready_i;
    assign push       = accept & gnt_is_read;
    assign pop        = cke_i & m_rvalid_i & ~fifo_empty;

    assign s_rdata_o  = {N_PORTS{m_rdata_i}};
    assign pending_o  = count_q;
    assign err_o      = err_q;

    always_comb begin
        s_ready_o  = '0;
        s_rvalid_o = '0;
        s_ready_o[grant]                = accept;
        s_rvalid_o[fifo_mem_q[rd_ptr_q]] = pop;
    end

    // Next-state logic; with cke_i low every _d equals its _q.
    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        fifo_mem_d  = fifo_mem_q;

        if (cke_i) begin
            // Requested but not accepted (cache stall or FIFO block): lock.
            if (accept) begin
                lock_d = 1'b0;
            end else if (gnt_avalid) begin
                lock_d      = 1'b1;
                lock_port_d = grant;
            end

            if (accept && (ARB_MODE == 0)) begin
                rr_ptr_d = (int'(grant) == N_PORTS - 1) ? '0 : grant + 1'b1;
            end

            if (push) begin
                fifo_mem_d[wr_ptr_q] = grant;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end

            if (m_rvalid_i && fifo_empty) begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            lock_port_q <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // NOTE: tag storage is not reset; the occupancy count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_iob_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for iob_cache_port_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus. Per-cycle table rows drive inputs and
// give the expected handshake outputs; accepted reads feed a port-ID
// scoreboard queue that is popped whenever the cache returns rvalid.
// ---------------------------------------------------------------------------
module tb_iob_cache_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        logic       cke;
        logic [3:0] avalid;
        logic [3:0] wr;
        logic       m_ready;
        logic       m_rvalid;
        logic       exp_mav;
        logic [3:0] exp_ready;
        int         exp_gnt;
        int         exp_pend;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              cke;
    logic [NP-1:0]     avalid;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP*SW-1:0]  wstrb;
    logic              m_ready;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;

    logic [NP-1:0]     ready_rr, rvalid_rr, ready_fp, rvalid_fp;
    logic [NP*DW-1:0]  rdata_rr, rdata_fp;
    logic              mav_rr, mav_fp;
    logic [AW-1:0]     maddr_rr, maddr_fp;
    logic [DW-1:0]     mwdata_rr, mwdata_fp;
    logic [SW-1:0]     mwstrb_rr, mwstrb_fp;
    logic [2:0]        pend_rr, pend_fp;
    logic              err_rr, err_fp;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    int   sb[$];
    logic [AW-1:0] port_addr [NP];

    iob_cache_port_arbiter #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .OUTST_W(2), .ARB_MODE(0)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .s_avalid_i(avalid), .s_addr_i(addr), .s_wdata_i(wdata), .s_wstrb_i(wstrb),
        .s_ready_o(ready_rr), .s_rvalid_o(rvalid_rr), .s_rdata_o(rdata_rr),
        .m_avalid_o(mav_rr), .m_addr_o(maddr_rr), .m_wdata_o(mwdata_rr), .m_wstrb_o(mwstrb_rr),
        .m_ready_i(m_ready), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
        .pending_o(pend_rr), .err_o(err_rr)
    );

    iob_cache_port_arbiter #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .OUTST_W(2), .ARB_MODE(1)
    ) dut_fp (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .s_avalid_i(avalid), .s_addr_i(addr), .s_wdata_i(wdata), .s_wstrb_i(wstrb),
        .s_ready_o(ready_fp), .s_rvalid_o(rvalid_fp), .s_rdata_o(rdata_fp),
        .m_avalid_o(mav_fp), .m_addr_o(maddr_fp), .m_wdata_o(mwdata_fp), .m_wstrb_o(mwstrb_fp),
        .m_ready_i(m_ready), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
        .pending_o(pend_fp), .err_o(err_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic [3:0] av, input logic [3:0] wr,
                                input logic rdy, input logic rv, input logic e_mav,
                                input logic [3:0] e_rdy, input int e_gnt, input int e_pend);
        vec_t v;
        v.cke = c; v.avalid = av; v.wr = wr; v.m_ready = rdy; v.m_rvalid = rv;
        v.exp_mav = e_mav; v.exp_ready = e_rdy; v.exp_gnt = e_gnt; v.exp_pend = e_pend;
        return v;
    endfunction

    // Leaves the bench one time unit after the reset edge with rst low.
    task automatic do_reset();
        rst = 1'b1; cke = 1'b1; avalid = '0; wstrb = '0;
        m_ready = 1'b0; m_rvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic apply_row(input int n);
        vec_t v;
        logic [3:0] exp_rv;
        int port;
        v = vecs[n];
        cke = v.cke; avalid = v.avalid; m_ready = v.m_ready; m_rvalid = v.m_rvalid;
        for (int p = 0; p < NP; p++) wstrb[p*SW +: SW] = v.wr[p] ? 4'hF : 4'h0;
        #1;
        check($sformatf("row%0d ready", n), ready_rr, v.exp_ready);
        check($sformatf("row%0d m_avalid", n), mav_rr, v.exp_mav);
        check($sformatf("row%0d pending", n), pend_rr, v.exp_pend);
        if (v.exp_mav) begin
            check($sformatf("row%0d m_addr", n), maddr_rr, port_addr[v.exp_gnt]);
            check($sformatf("row%0d m_wdata", n), mwdata_rr, 32'hA0 + v.exp_gnt);
            check($sformatf("row%0d m_wstrb", n), mwstrb_rr, v.wr[v.exp_gnt] ? 4'hF : 4'h0);
        end
        exp_rv = '0;
        if (v.m_rvalid && v.cke) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL row%0d scoreboard actual=empty required=entry", n);
            end else begin
                port = sb.pop_front();
                exp_rv[port] = 1'b1;
            end
        end
        check($sformatf("row%0d rvalid", n), rvalid_rr, exp_rv);
        if (v.exp_ready != 0 && !v.wr[v.exp_gnt]) sb.push_back(v.exp_gnt);
        @(posedge clk); #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int n = lo; n < hi; n++) apply_row(n);
    endtask

    initial begin
        int s0, s1, s2, s3, s4;
        port_addr[0] = 30'h010; port_addr[1] = 30'h020;
        port_addr[2] = 30'h100; port_addr[3] = 30'h040;
        for (int p = 0; p < NP; p++) begin
            addr[p*AW +: AW]  = port_addr[p];
            wdata[p*DW +: DW] = 32'hA0 + p;
        end
        m_rdata = '0;

        // Stall lock: port 2 stalls 3 cycles, port 0 joins in cycle 2.
        s0 = vecs.size();
        vecs.push_back(mk(1, 4'b0100, 0, 0, 0, 1, 4'b0000, 2, 0));
        vecs.push_back(mk(1, 4'b0101, 0, 0, 0, 1, 4'b0000, 2, 0));
        vecs.push_back(mk(1, 4'b0101, 0, 0, 0, 1, 4'b0000, 2, 0));
        vecs.push_back(mk(1, 4'b0101, 0, 1, 0, 1, 4'b0100, 2, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 1, 0, 1, 4'b0001, 0, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 2));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 1));
        // Round-robin fairness: all four ports read; 0,1,2,3 then 0 again once a slot frees.
        s1 = vecs.size();
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 1, 4'b0010, 1, 1));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 1, 4'b0100, 2, 2));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 1, 4'b1000, 3, 3));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 1, 0, 4'b0000, 0, 4));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 1, 4'b0001, 0, 3));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 4 - k));
        // FIFO full: 4 reads, a write still passes, a 5th read waits for a pop.
        s2 = vecs.size();
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 4'(1 << k), 0, 1, 0, 1, 4'(1 << k), k, k));
        vecs.push_back(mk(1, 4'b0010, 4'b0010, 1, 0, 1, 4'b0010, 1, 4));
        vecs.push_back(mk(1, 4'b0100, 0, 1, 0, 0, 4'b0000, 2, 4));
        vecs.push_back(mk(1, 4'b0100, 0, 1, 1, 0, 4'b0000, 2, 4));
        vecs.push_back(mk(1, 4'b0100, 0, 1, 0, 1, 4'b0100, 2, 3));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 4 - k));
        // Clock enable: three reads, then two frozen cycles.
        s3 = vecs.size();
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 4'(1 << k), 0, 1, 0, 1, 4'(1 << k), k, k));
        vecs.push_back(mk(0, 4'b1111, 0, 1, 1, 0, 4'b0000, 0, 3));
        vecs.push_back(mk(0, 4'b1111, 0, 1, 1, 0, 4'b0000, 0, 3));
        s4 = vecs.size();

        do_reset();
        #1;
        check("reset m_avalid", mav_rr, 1'b0);
        check("reset ready", ready_rr, 4'b0);
        check("reset rvalid", rvalid_rr, 4'b0);
        check("reset pending", pend_rr, 3'd0);
        check("reset err", err_rr, 1'b0);

        run_rows(s0, s1);
        do_reset();
        run_rows(s1, s2);
        do_reset();
        run_rows(s2, s3);

        // Unexpected rvalid with an empty FIFO.
        do_reset();
        m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
        #1;
        check("err rvalid", rvalid_rr, 4'b0);
        check("err before edge", err_rr, 1'b0);
        check("rdata port0", rdata_rr[0 +: DW], 32'hDEADBEEF);
        check("rdata port3", rdata_rr[3*DW +: DW], 32'hDEADBEEF);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        #1;
        check("err set", err_rr, 1'b1);
        check("err pending", pend_rr, 3'd0);
        @(posedge clk); #1;
        check("err sticky", err_rr, 1'b1);

        // cke low mid-stream, then reset with three reads outstanding.
        do_reset();
        run_rows(s3, s4);
        rst = 1'b1; cke = 1'b1; avalid = '0; m_ready = 1'b0; m_rvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        #1;
        check("rst pending", pend_rr, 3'd0);
        check("rst err", err_rr, 1'b0);
        avalid = 4'b1111;
        #1;
        check("rst pointer m_avalid", mav_rr, 1'b1);
        check("rst pointer addr", maddr_rr, port_addr[0]);
        @(posedge clk); #1;
        avalid = '0; m_rvalid = 1'b1;
        #1;
        check("stale rvalid", rvalid_rr, 4'b0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        check("stale err", err_rr, 1'b1);

        // Fixed priority: port 1 starves port 3 until it drops.
        do_reset();
        avalid = 4'b1010; m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("fp cyc%0d ready", k), ready_fp, 4'b0010);
            check($sformatf("fp cyc%0d addr", k), maddr_fp, port_addr[1]);
            @(posedge clk); #1;
        end
        avalid = 4'b1000;
        #1;
        check("fp port3 ready", ready_fp, 4'b1000);
        check("fp port3 addr", maddr_fp, port_addr[3]);
        @(posedge clk); #1;
        avalid = '0; m_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
